// File: rtl/mbv_pkg.sv
// Shared constants and state encoding for the matrix-by-vector unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mbv_pkg;

    // Rows are padded up to the next NI granule; an exact multiple still gains a full granule.
    function automatic int calc_total(input int n, input int ni);
        return n + (ni - (n % ni));
    endfunction

    localparam int MBV_N            = 3;
    localparam int MBV_NI           = 8;
    localparam int MBV_UNITS        = 4;
    localparam int MBV_EW           = 32;
    localparam int MBV_FRAC         = 16;
    localparam int MBV_TOTAL        = calc_total(MBV_N, MBV_NI);
    localparam int MBV_BEATS_PER_OP = MBV_TOTAL / MBV_UNITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage

// File: rtl/lane_narrow.sv
// Narrows one wide-precision lane (2*FRAC_BITS fraction) to element_width (FRAC_BITS fraction).
// Latency: combinational.
// Backpressure: none; output follows input.
// Ports: lane (2*element_width, signed) in; narrow (element_width) out; clip out (lane was clamped).
// Build option: RESULT_SATURATE_EN clamps out-of-range values and raises clip;
// otherwise the value is truncated and clip is 0.
module lane_narrow #(
    parameter int element_width = 32,
    parameter int FRAC_BITS     = 16
) (
    input  logic [2*element_width-1:0] lane,
    output logic [element_width-1:0]   narrow,
    output logic                       clip
);

    logic signed [2*element_width-1:0] shifted;

    assign shifted = $signed(lane) >>> FRAC_BITS;

`ifdef RESULT_SATURATE_EN
    // In range when every bit from the element sign bit upward is a copy of the sign.
    logic [element_width:0] upper;
    logic                   in_range;

    assign upper    = shifted[2*element_width-1:element_width-1];
    assign in_range = (&upper) | ~(|upper);
    assign clip     = ~in_range;

    always_comb begin
        narrow = shifted[element_width-1:0];
        if (!in_range) begin
            narrow = shifted[2*element_width-1] ? {1'b1, {(element_width-1){1'b0}}}
                                                : {1'b0, {(element_width-1){1'b1}}};
        end
    end
`else
    // Upper bits are discarded by plain truncation.
    logic unused_hi;

    assign unused_hi = ^shifted[2*element_width-1:element_width];
    assign narrow    = shifted[element_width-1:0];
    assign clip      = 1'b0;
`endif

endmodule

// File: rtl/mbv_result_collector.sv
// Collects decoder beats, narrows each lane and packs real rows into out_full; padding rows dropped.
// Latency: done pulses the cycle after the last beat is captured; out_full final in that cycle.
// Backpressure: none; every in_valid beat in COLLECT is taken (one per cycle, gaps allowed).
// Ports: clk, reset (async active-low), start (level, low aborts/rearms), in_valid, in_data
// (MSB lane = lowest row) in; out_full (row 0 in MSB slot), busy, done, overflow (sticky) out.
// Build option: RESULT_SATURATE_EN enables lane saturation and the overflow flag.
module mbv_result_collector
    import mbv_pkg::*;
#(
    parameter int no_of_eqn_per_cluster = MBV_N,
    parameter int element_width         = MBV_EW,
    parameter int no_of_units           = MBV_UNITS,
    parameter int NI                    = MBV_NI,
    parameter int FRAC_BITS             = MBV_FRAC
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         in_valid,
    input  logic [2*element_width*no_of_units-1:0]       in_data,
    output logic [no_of_eqn_per_cluster*element_width-1:0] out_full,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         overflow
);

    localparam int TOTAL = calc_total(no_of_eqn_per_cluster, NI);
    localparam int BEATS = TOTAL / no_of_units;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t                   state;
    logic [CNT_W-1:0]         beat_cnt;
    logic [element_width-1:0] lane_nar [no_of_units];
    logic [no_of_units-1:0]   lane_clip;
    logic                     capture;
    logic                     cap_clip;

    for (genvar k = 0; k < no_of_units; k++) begin : g_lane
        lane_narrow #(
            .element_width(element_width),
            .FRAC_BITS    (FRAC_BITS)
        ) u_lane_narrow (
            .lane  (in_data[2*element_width*(k+1)-1 -: 2*element_width]),
            .narrow(lane_nar[k]),
            .clip  (lane_clip[k])
        );
    end

    // A beat only counts in COLLECT with start still high; an abort cycle writes nothing.
    assign capture = (state == COLLECT) && start && in_valid;

    // Only lanes that land in a real row contribute to overflow; padding lanes are dropped.
    always_comb begin
        cap_clip = 1'b0;
        for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
            if (capture && (beat_cnt == CNT_W'(r / no_of_units))) begin
                cap_clip = cap_clip | lane_clip[no_of_units-1-(r % no_of_units)];
            end
        end
    end

    // Row r arrives on beat r/units in lane units-1-(r%units).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_full <= '0;
        end else begin
            for (int r = 0; r < no_of_eqn_per_cluster; r++) begin
                if (capture && (beat_cnt == CNT_W'(r / no_of_units))) begin
                    out_full[element_width*(no_of_eqn_per_cluster-r)-1 -: element_width]
                        <= lane_nar[no_of_units-1-(r % no_of_units)];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            beat_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (!start) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                    end else if (in_valid) begin
                        overflow <= overflow | cap_clip;
                        if (beat_cnt == LAST_BEAT) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbv_result_collector.sv
// Directed bench for mbv_result_collector with hand-computed expected values.
// Latency: n/a.
// Backpressure: n/a.
module tb_mbv_result_collector;

    localparam int EW = 32;
    localparam int U  = 4;
    localparam int N  = 3;

`ifdef RESULT_SATURATE_EN
    localparam logic [31:0] SAT_HI  = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_LO  = 32'h8000_0000;
    localparam logic        OVF_EXP = 1'b1;
`else
    localparam logic [31:0] SAT_HI  = 32'h0000_0000;
    localparam logic [31:0] SAT_LO  = 32'h0000_0000;
    localparam logic        OVF_EXP = 1'b0;
`endif

    logic                clk;
    logic                reset;
    logic                start;
    logic                in_valid;
    logic [2*EW*U-1:0]   in_data;
    logic [N*EW-1:0]     out_full;
    logic                busy;
    logic                done;
    logic                overflow;

    int n_cmp;
    int n_bad;

    mbv_result_collector dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .out_full(out_full),
        .busy    (busy),
        .done    (done),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole number in lane format (32 fraction bits).
    function automatic logic [63:0] fx(input int whole);
        return {whole[31:0], 32'h0};
    endfunction

    // First argument is the MSB lane, i.e. the lowest row of the beat.
    function automatic logic [255:0] bt(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input logic [63:0] d);
        return {a, b, c, d};
    endfunction

    function automatic logic [95:0] ex3(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return {a, b, c};
    endfunction

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2 reset = 1'b0;
        tick();
        tick();
        chk("rst_out_full", 128'(out_full), 128'(96'h0));
        chk("rst_busy",     128'(busy),     128'(1'b0));
        chk("rst_done",     128'(done),     128'(1'b0));
        chk("rst_overflow", 128'(overflow), 128'(1'b0));
        reset = 1'b1;
        tick();

        // T1: basic two-beat collection
        start = 1'b1;
        tick();
        chk("t1_busy", 128'(busy), 128'(1'b1));
        in_valid = 1'b1;
        in_data  = bt(fx(1), fx(2), fx(3), fx(4));
        tick();
        chk("t1_done_early", 128'(done), 128'(1'b0));
        in_data = bt(fx(5), fx(5), fx(5), fx(5));
        tick();
        chk("t1_done",     128'(done),     128'(1'b1));
        chk("t1_out_full", 128'(out_full), 128'(ex3(32'h0001_0000, 32'h0002_0000, 32'h0003_0000)));
        chk("t1_overflow", 128'(overflow), 128'(1'b0));
        chk("t1_busy_off", 128'(busy),     128'(1'b0));
        in_valid = 1'b0;
        tick();
        chk("t1_done_once", 128'(done), 128'(1'b0));
        in_valid = 1'b1;
        in_data  = bt(fx(9), fx(9), fx(9), fx(9));
        tick();
        chk("t1_hold_keep", 128'(out_full), 128'(ex3(32'h0001_0000, 32'h0002_0000, 32'h0003_0000)));
        chk("t1_hold_done", 128'(done),     128'(1'b0));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();

        // T2: negative lanes; beat coincident with start is not captured
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = bt(fx(7), fx(7), fx(7), fx(7));
        tick();
        in_data = bt(64'hFFFF_FFFD_8000_0000, fx(6), fx(-3), 64'h0);
        tick();
        chk("t2_same_cycle", 128'(done), 128'(1'b0));
        in_data = '0;
        tick();
        chk("t2_done",     128'(done),     128'(1'b1));
        chk("t2_out_full", 128'(out_full), 128'(ex3(32'hFFFD_8000, 32'h0006_0000, 32'hFFFD_0000)));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        tick();

        // T3: out-of-range lanes (clamped or truncated depending on build)
        start = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = bt(64'h0001_0000_0000_0000, fx(1), 64'hFFFF_0000_0000_0000, 64'h0);
        tick();
        chk("t3_ovf_set", 128'(overflow), 128'(OVF_EXP));
        in_data = '0;
        tick();
        chk("t3_done",     128'(done),     128'(1'b1));
        chk("t3_out_full", 128'(out_full), 128'(ex3(SAT_HI, 32'h0001_0000, SAT_LO)));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        tick();
        chk("t3_ovf_sticky", 128'(overflow), 128'(OVF_EXP));

        // T4: abort after first beat, then a clean restart
        start = 1'b1;
        tick();
        chk("t4_ovf_clr", 128'(overflow), 128'(1'b0));
        in_valid = 1'b1;
        in_data  = bt(fx(8), fx(9), fx(10), 64'h0);
        tick();
        chk("t4_beat0_done", 128'(done), 128'(1'b0));
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("t4_abort_busy", 128'(busy),     128'(1'b0));
        chk("t4_abort_done", 128'(done),     128'(1'b0));
        chk("t4_abort_rows", 128'(out_full), 128'(ex3(32'h0008_0000, 32'h0009_0000, 32'h000A_0000)));
        tick();
        chk("t4_abort_nodone", 128'(done), 128'(1'b0));
        start = 1'b1;
        tick();
        chk("t4_restart_busy", 128'(busy), 128'(1'b1));
        in_valid = 1'b1;
        in_data  = bt(fx(11), fx(12), fx(13), 64'h0);
        tick();
        chk("t4_cnt_cleared", 128'(done),     128'(1'b0));
        chk("t4_rows",        128'(out_full), 128'(ex3(32'h000B_0000, 32'h000C_0000, 32'h000D_0000)));
        in_data = '0;
        tick();
        chk("t4_done", 128'(done), 128'(1'b1));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        tick();

        // T5: gaps between beats
        start = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = bt(fx(3), fx(2), fx(1), 64'h0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_gap1", 128'(done), 128'(1'b0));
        tick();
        chk("t5_gap2", 128'(done), 128'(1'b0));
        in_valid = 1'b1;
        in_data  = '0;
        tick();
        chk("t5_done",     128'(done),     128'(1'b1));
        chk("t5_out_full", 128'(out_full), 128'(ex3(32'h0003_0000, 32'h0002_0000, 32'h0001_0000)));
        in_valid = 1'b0;
        tick();
        chk("t5_done_once", 128'(done), 128'(1'b0));
        in_valid = 1'b1;
        in_data  = bt(fx(9), fx(9), fx(9), fx(9));
        tick();
        chk("t5_hold_keep", 128'(out_full), 128'(ex3(32'h0003_0000, 32'h0002_0000, 32'h0001_0000)));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();
        tick();

        // T6: asynchronous reset between clock edges during COLLECT
        start = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = bt(fx(4), fx(4), fx(4), 64'h0);
        tick();
        chk("t6_pre_busy", 128'(busy),     128'(1'b1));
        chk("t6_pre_rows", 128'(out_full), 128'(ex3(32'h0004_0000, 32'h0004_0000, 32'h0004_0000)));
        #2 reset = 1'b0;
        #1;
        chk("t6_out_full", 128'(out_full), 128'(96'h0));
        chk("t6_busy",     128'(busy),     128'(1'b0));
        chk("t6_done",     128'(done),     128'(1'b0));
        chk("t6_overflow", 128'(overflow), 128'(1'b0));
        #1 reset = 1'b1;
        // From IDLE this edge only enters COLLECT; the pending beat must not land.
        tick();
        chk("t6_idle_rows", 128'(out_full), 128'(96'h0));
        chk("t6_idle_busy", 128'(busy),     128'(1'b1));
        in_valid = 1'b0;
        start    = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
